// File: rtl/me_run_ctrl_if.sv
// me_top request/acknowledge bundle: four-phase req/ack plus result bus.
// Master drives req; slave (me_top) returns ack and the result.
interface me_run_ctrl_if;
  logic        req;
  logic        ack;
  logic [15:0] min_sad;
  logic [11:0] min_mvec;

  modport master (
    output req,
    input  ack,
    input  min_sad,
    input  min_mvec
  );

  modport slave (
    input  req,
    output ack,
    output min_sad,
    output min_mvec
  );
endinterface

// File: rtl/me_run_ctrl.sv
// me_top run controller: button debounce, req/ack handshake, result latch.
// Optional watchdog on the request phase when ME_RUN_TIMEOUT_EN is defined.
module me_run_db #(
  parameter logic [15:0] DB_CYCLES = 16'd50000
) (
  input  logic clk,
  input  logic RSTN,
  input  logic btn_n,
  output logic press
);
  logic        s1;
  logic        s2;
  logic        lvl;
  logic [15:0] cnt;

  always_ff @(posedge clk or negedge RSTN) begin
    if (!RSTN) begin
      s1    <= 1'b1;
      s2    <= 1'b1;
      lvl   <= 1'b1;
      cnt   <= 16'd0;
      press <= 1'b0;
    end else begin
      s1    <= btn_n;
      s2    <= s1;
      press <= 1'b0;
      if (s2 == lvl) begin
        cnt <= 16'd0;
      end else if (cnt == DB_CYCLES - 16'd1) begin
        // level accepted; a press is its 1->0 edge
        lvl   <= s2;
        cnt   <= 16'd0;
        press <= ~s2;
      end else begin
        cnt <= cnt + 16'd1;
      end
    end
  end
endmodule

module me_run_ctrl #(
  parameter logic [15:0]      DB_CYCLES   = 16'd50000,
  parameter int unsigned      LAT_W       = 24,
  parameter logic [LAT_W-1:0] TIMEOUT_CYC = {LAT_W{1'b1}}
) (
  input  logic             clk,
  input  logic             RSTN,
  input  logic             SW4N,
  input  logic             SW5N,
  me_run_ctrl_if.master    me,
  output logic [15:0]      res_sad,
  output logic [11:0]      res_mvec,
  output logic [LAT_W-1:0] latency,
  output logic [7:0]       run_cnt,
  output logic             busy,
  output logic             aborted
);
`ifdef ME_RUN_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_REL
  } state_t;

  logic start_p;
  logic abort_p;

  me_run_db #(.DB_CYCLES(DB_CYCLES)) u_db_start (
    .clk   (clk),
    .RSTN  (RSTN),
    .btn_n (SW4N),
    .press (start_p)
  );

  me_run_db #(.DB_CYCLES(DB_CYCLES)) u_db_abort (
    .clk   (clk),
    .RSTN  (RSTN),
    .btn_n (SW5N),
    .press (abort_p)
  );

  state_t           st_q,   st_n;
  logic             req_q,  req_n;
  logic             ab_q,   ab_n;
  logic [LAT_W-1:0] lat_q,  lat_n;
  logic [LAT_W-1:0] lat_r_q, lat_r_n;
  logic [15:0]      sad_q,  sad_n;
  logic [11:0]      mv_q,   mv_n;
  logic [7:0]       cnt_q,  cnt_n;
  logic [LAT_W-1:0] lat_inc;

  assign lat_inc = (&lat_q) ? lat_q : lat_q + LAT_W'(1);

  always_ff @(posedge clk or negedge RSTN) begin
    if (!RSTN) begin
      st_q    <= S_IDLE;
      req_q   <= 1'b0;
      ab_q    <= 1'b0;
      lat_q   <= '0;
      lat_r_q <= '0;
      sad_q   <= 16'd0;
      mv_q    <= 12'd0;
      cnt_q   <= 8'd0;
    end else begin
      st_q    <= st_n;
      req_q   <= req_n;
      ab_q    <= ab_n;
      lat_q   <= lat_n;
      lat_r_q <= lat_r_n;
      sad_q   <= sad_n;
      mv_q    <= mv_n;
      cnt_q   <= cnt_n;
    end
  end

  always_comb begin
    st_n    = st_q;
    req_n   = req_q;
    ab_n    = ab_q;
    lat_n   = lat_q;
    lat_r_n = lat_r_q;
    sad_n   = sad_q;
    mv_n    = mv_q;
    cnt_n   = cnt_q;
    unique case (st_q)
      S_IDLE: begin
        // ack still high from a prior run blocks a new request
        if (start_p && !me.ack) begin
          st_n  = S_REQ;
          req_n = 1'b1;
          lat_n = '0;
          ab_n  = 1'b0;
        end
      end
      S_REQ: begin
        lat_n = lat_inc;
        if (me.ack) begin
          sad_n   = me.min_sad;
          mv_n    = me.min_mvec;
          lat_r_n = lat_q;
          cnt_n   = cnt_q + 8'd1;
          req_n   = 1'b0;
          st_n    = S_REL;
        end else if (abort_p ||
                     (TO_EN && lat_q == TIMEOUT_CYC)) begin
          req_n = 1'b0;
          ab_n  = 1'b1;
          st_n  = S_REL;
        end
      end
      S_REL: begin
        if (!me.ack) st_n = S_IDLE;
      end
      default: st_n = S_IDLE;
    endcase
  end

  assign me.req   = req_q;
  assign res_sad  = sad_q;
  assign res_mvec = mv_q;
  assign latency  = lat_r_q;
  assign run_cnt  = cnt_q;
  assign busy     = (st_q != S_IDLE);
  assign aborted  = ab_q;
endmodule

// File: tb/tb_me_run_ctrl.sv
// Scoreboard bench for me_run_ctrl: run-end records queued by stimulus,
// checked by a monitor on every req fall.
module tb_me_run_ctrl;
  logic        clk = 1'b0;
  logic        RSTN;
  logic        SW4N;
  logic        SW5N;
  logic [15:0] res_sad;
  logic [11:0] res_mvec;
  logic [23:0] latency;
  logic [7:0]  run_cnt;
  logic        busy;
  logic        aborted;

  me_run_ctrl_if bus ();

  me_run_ctrl #(
    .DB_CYCLES   (16'd4),
    .LAT_W       (24),
    .TIMEOUT_CYC (24'd50)
  ) dut (
    .clk      (clk),
    .RSTN     (RSTN),
    .SW4N     (SW4N),
    .SW5N     (SW5N),
    .me       (bus),
    .res_sad  (res_sad),
    .res_mvec (res_mvec),
    .latency  (latency),
    .run_cnt  (run_cnt),
    .busy     (busy),
    .aborted  (aborted)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] sad;
    logic [11:0] mvec;
    logic [23:0] lat;
    logic [7:0]  cnt;
    logic        ab;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  logic req_prev = 1'b0;

  function automatic void chk(string name, logic [31:0] act,
                              logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  always @(negedge clk) begin
    if (RSTN && req_prev && !bus.req) begin
      if (q.size() == 0) begin
        chk("unexpected_run_end", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("res_sad", {16'd0, res_sad}, {16'd0, e.sad});
        chk("res_mvec", {20'd0, res_mvec}, {20'd0, e.mvec});
        chk("latency", {8'd0, latency}, {8'd0, e.lat});
        chk("run_cnt", {24'd0, run_cnt}, {24'd0, e.cnt});
        chk("aborted", {31'd0, aborted}, {31'd0, e.ab});
        chk("busy_end", {31'd0, busy}, 32'd1);
      end
    end
    req_prev <= bus.req;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_req();
    int n = 0;
    while (!bus.req && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("req_rise", {31'd0, bus.req}, 32'd1);
  endtask

  task automatic start_run();
    @(posedge clk);
    #1 SW4N = 1'b0;
    wait_req();
    SW4N = 1'b1;
  endtask

  task automatic press(input bit abort_btn);
    @(posedge clk);
    #1;
    if (abort_btn) SW5N = 1'b0;
    else SW4N = 1'b0;
    tick(9);
    SW4N = 1'b1;
    SW5N = 1'b1;
    tick(8);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got hang expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    RSTN         = 1'b0;
    SW4N         = 1'b1;
    SW5N         = 1'b1;
    bus.ack      = 1'b0;
    bus.min_sad  = 16'd0;
    bus.min_mvec = 12'd0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_req", {31'd0, bus.req}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_aborted", {31'd0, aborted}, 32'd0);
    chk("rst_sad", {16'd0, res_sad}, 32'd0);
    chk("rst_mvec", {20'd0, res_mvec}, 32'd0);
    chk("rst_latency", {8'd0, latency}, 32'd0);
    chk("rst_run_cnt", {24'd0, run_cnt}, 32'd0);
    RSTN = 1'b1;
    tick(3);

    // start glitch of 3 cycles is rejected
    SW4N = 1'b0;
    tick(3);
    SW4N = 1'b1;
    tick(10);
    @(negedge clk);
    chk("glitch_req", {31'd0, bus.req}, 32'd0);

    // real press: req rises on the 7th edge after the fall
    @(posedge clk);
    #1 SW4N = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    chk("press_req_e6", {31'd0, bus.req}, 32'd0);
    @(negedge clk);
    chk("press_req_e7", {31'd0, bus.req}, 32'd1);
    chk("busy_req", {31'd0, busy}, 32'd1);
    q.push_back('{16'h01A3, 12'hF21, 24'd100, 8'd1, 1'b0});
    for (int i = 1; i <= 100; i++) begin
      @(posedge clk);
      #1;
      if (i == 3) SW4N = 1'b1;
    end
    bus.ack      = 1'b1;
    bus.min_sad  = 16'h01A3;
    bus.min_mvec = 12'hF21;
    tick(3);
    bus.ack = 1'b0;
    tick(3);

    // abort before ack; late ack pulse afterwards
    start_run();
    q.push_back('{16'h01A3, 12'hF21, 24'd100, 8'd1, 1'b1});
    press(1'b1);
    @(negedge clk);
    chk("abort_req", {31'd0, bus.req}, 32'd0);
    @(posedge clk);
    #1 bus.ack = 1'b1;
    tick(3);
    bus.ack = 1'b0;
    tick(3);
    @(negedge clk);
    chk("abort_idle", {31'd0, busy}, 32'd0);
    chk("abort_cnt", {24'd0, run_cnt}, 32'd1);

    // abort press and ack sampled on the same edge
    start_run();
    @(posedge clk);
    #1 SW5N = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    bus.ack      = 1'b1;
    bus.min_sad  = 16'h0BEE;
    bus.min_mvec = 12'h0A5;
    q.push_back('{16'h0BEE, 12'h0A5, 24'd7, 8'd2, 1'b0});
    tick(3);
    SW5N = 1'b1;
    tick(8);

    // ack held high: start presses ignored
    press(1'b0);
    @(negedge clk);
    chk("hold_ack_req", {31'd0, bus.req}, 32'd0);
    chk("hold_ack_busy", {31'd0, busy}, 32'd1);
    bus.ack = 1'b0;
    tick(4);
    @(negedge clk);
    chk("no_press_req", {31'd0, bus.req}, 32'd0);
    chk("release_idle", {31'd0, busy}, 32'd0);
    bus.ack = 1'b1;
    press(1'b0);
    @(negedge clk);
    chk("idle_ack_req", {31'd0, bus.req}, 32'd0);
    chk("idle_ack_busy", {31'd0, busy}, 32'd0);
    bus.ack = 1'b0;
    tick(3);
    start_run();
    q.push_back('{16'h0007, 12'h123, 24'd20, 8'd3, 1'b0});
    tick(20);
    bus.ack      = 1'b1;
    bus.min_sad  = 16'h0007;
    bus.min_mvec = 12'h123;
    tick(2);
    bus.ack = 1'b0;
    tick(3);

    // watchdog behaviour with ack tied low
    start_run();
    q.push_back('{16'h0007, 12'h123, 24'd20, 8'd3, 1'b1});
`ifdef ME_RUN_TIMEOUT_EN
    begin
      int n = 0;
      while (bus.req && n < 100) begin
        @(negedge clk);
        n++;
      end
      chk("timeout_drop", {31'd0, bus.req}, 32'd0);
    end
`else
    begin
      int lows = 0;
      for (int i = 0; i < 1000; i++) begin
        @(negedge clk);
        if (!bus.req) lows++;
      end
      chk("no_timeout_hold", lows, 32'd0);
      press(1'b1);
    end
`endif
    tick(3);
    @(negedge clk);
    chk("timeout_idle", {31'd0, busy}, 32'd0);

    // reset mid-run drops req asynchronously
    start_run();
    tick(5);
    #2 RSTN = 1'b0;
    #1;
    chk("rst_mid_req", {31'd0, bus.req}, 32'd0);
    chk("rst_mid_cnt", {24'd0, run_cnt}, 32'd0);
    chk("rst_mid_sad", {16'd0, res_sad}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    RSTN = 1'b1;
    tick(3);

    chk("queue_empty", q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule
